// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage feeding the opcode decoder. Owns the PC,
// issues word fetches, buffers returned words with their PCs in a small FIFO
// and hands them on through a valid/ready handshake. A redirect flushes
// buffered words and discards fetches that are still in flight.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous reset, active low
//   imem_req_o     fetch request, accepted in the cycle it is raised
//   imem_addr_o    word-aligned fetch address, valid with imem_req_o
//   imem_rvalid_i  in-order response valid (latency >= 1)
//   imem_rdata_i   response instruction word
//   redirect_i     load redirect_pc_i as the new PC and flush
//   redirect_pc_i  redirect target, bits [1:0] ignored
//   inst_valid_o   inst_o/pc_o/op_o hold a fetched instruction
//   inst_ready_i   consumer accepts the head instruction
//   inst_o         head instruction, NOP (32'h13) when empty
//   pc_o           address of inst_o, 0 when empty
//   op_o           inst_o[6:0] for the decoder
//   fetch_count_o  completed handshakes since reset
//                  (only with FETCH_PERF_CNT_EN defined)
//
// Build option: define FETCH_PERF_CNT_EN to add fetch_count_o.

module instruction_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0040_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic [31:0] inst_o,
   output logic [31:0] pc_o,
   output logic [6:0]  op_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_count_o
`endif
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

   logic [31:0]   r_pc;
   logic [31:0]   r_tag_pc;
   logic [CW-1:0] r_out;
   logic [CW-1:0] r_drop;
   logic [CW-1:0] r_count;
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [31:0]   r_inst [FIFO_DEPTH];
   logic [31:0]   r_tag  [FIFO_DEPTH];

   logic          w_valid;
   logic          w_pop;
   logic          w_rsp;
   logic          w_discard;
   logic          w_push;
   logic          w_issue;
   logic [CW:0]   w_used;
   logic [CW-1:0] w_out_rsp;
   logic [31:0]   w_redir_pc;

   assign w_valid    = (r_count != '0);
   assign w_pop      = w_valid & inst_ready_i;
   // Responses with nothing outstanding are not ours.
   assign w_rsp      = imem_rvalid_i & (r_out != '0);
   assign w_discard  = w_rsp & (r_drop != '0);
   assign w_push     = w_rsp & (r_drop == '0) & ~redirect_i;
   assign w_out_rsp  = r_out - CW'(w_rsp);
   assign w_redir_pc = redirect_pc_i & ~32'h3;

   // Buffered plus in-flight words bound the FIFO fill. A slot being
   // popped this cycle counts as free, which lets a latency-1 memory
   // stream one word per cycle through a 2-entry buffer.
   assign w_used  = {1'b0, r_count} + {1'b0, r_out}
                  - (CW+1)'(w_pop);
   assign w_issue = reset & ~redirect_i & (w_used < DEPTH_W);

   assign imem_req_o   = w_issue;
   assign imem_addr_o  = r_pc;
   assign inst_valid_o = w_valid;
   assign inst_o       = w_valid ? r_inst[r_rptr] : NOP;
   assign pc_o         = w_valid ? r_tag[r_rptr] : '0;
   assign op_o         = inst_o[6:0];

   // Responses return in order and stale ones are dropped before any
   // new-stream word arrives, so the PC of the next kept response is
   // just a running counter restarted on redirect.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc     <= RESET_PC;
         r_tag_pc <= RESET_PC;
         r_out    <= '0;
         r_drop   <= '0;
         r_count  <= '0;
         r_wptr   <= '0;
         r_rptr   <= '0;
      end else if (redirect_i) begin
         r_pc     <= w_redir_pc;
         r_tag_pc <= w_redir_pc;
         r_out    <= w_out_rsp;
         // Everything still in flight belongs to the old stream.
         r_drop   <= w_out_rsp;
         r_count  <= '0;
         r_wptr   <= '0;
         r_rptr   <= '0;
      end else begin
         if (w_issue) begin
            r_pc <= r_pc + 32'd4;
         end
         r_out <= w_out_rsp + CW'(w_issue);
         if (w_discard) begin
            r_drop <= r_drop - CW'(1);
         end
         if (w_push) begin
            r_wptr   <= r_wptr + AW'(1);
            r_tag_pc <= r_tag_pc + 32'd4;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_inst[r_wptr] <= imem_rdata_i;
         r_tag[r_wptr]  <= r_tag_pc;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_fetch_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fetch_cnt <= '0;
      end else if (w_pop) begin
         r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
   end

   assign fetch_count_o = r_fetch_cnt;
`endif

`ifndef SYNTHESIS
   a_no_overflow: assert property (
      @(posedge clk) disable iff (!reset)
      !(w_push && (r_count == CW'(FIFO_DEPTH))));
`endif

endmodule
